// File: rtl/addsub_share_ctrl_if.sv
// Handshake and operand/result bundle between two requesters and the shared
// nibble add/subtract controller.
interface addsub_share_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             req0;
   logic             req1;
   logic             sub0;
   logic             sub1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             ack0;
   logic             ack1;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;

   modport master (
      output req0, req1, sub0, sub1, a0, b0, a1, b1,
      input  ack0, ack1, busy, done, done_id, result, carry, overflow
   );

   modport slave (
      input  req0, req1, sub0, sub1, a0, b0, a1, b1,
      output ack0, ack1, busy, done, done_id, result, carry, overflow
   );
endinterface

// File: rtl/addsub_share_ctrl.sv
// Round-robin arbiter for two requesters sharing one 4-bit add/subtract slice;
// operates LSB nibble first and reports result, carry and signed overflow.
module addsub_share_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input logic                clk,
   input logic                rst,
   addsub_share_ctrl_if.slave bus
);
   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
   logic             sub_q, sub_d, id_q, id_d, c_q, c_d, last_q, last_d;
   logic             carry_q, carry_d, ovf_q, ovf_d, done_id_q, done_id_d;

   logic       winner;
   logic [3:0] a_nib, b_nib;
   logic       cin, c_msb, last_nib;
   logic [4:0] nib_sum;

   // Shared nibble slice: b is inverted and carry-in seeded with sub for a-b.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int k = 0; k < int'(NIB); k++) begin
         if (cnt_q == CntW'(k)) begin
            a_nib = a_q[4*k +: 4];
            b_nib = b_q[4*k +: 4] ^ {4{sub_q}};
         end
      end
      cin      = (cnt_q == '0) ? sub_q : c_q;
      nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, cin};
      c_msb    = a_nib[3] ^ b_nib[3] ^ nib_sum[3];
      last_nib = (cnt_q == CntW'(NIB - 1));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      id_d      = id_q;
      c_d       = c_q;
      last_d    = last_q;
      acc_d     = acc_q;
      result_d  = result_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      done_id_d = done_id_q;
      winner    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

      unique case (state_q)
         StIdle: begin
            if (bus.req0 || bus.req1) begin
               last_d  = winner;
               id_d    = winner;
               a_d     = winner ? bus.a1 : bus.a0;
               b_d     = winner ? bus.b1 : bus.b0;
               sub_d   = winner ? bus.sub1 : bus.sub0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            for (int k = 0; k < int'(NIB); k++) begin
               if (cnt_q == CntW'(k)) acc_d[4*k +: 4] = nib_sum[3:0];
            end
            c_d   = nib_sum[4];
            cnt_d = cnt_q + 1'b1;
            if (last_nib) begin
               result_d  = acc_d;
               carry_d   = nib_sum[4];
               ovf_d     = c_msb ^ nib_sum[4];
               done_id_d = id_q;
               cnt_d     = '0;
               state_d   = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         id_q      <= 1'b0;
         c_q       <= 1'b0;
         last_q    <= 1'b1;
         acc_q     <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sub_q     <= sub_d;
         id_q      <= id_d;
         c_q       <= c_d;
         last_q    <= last_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         done_id_q <= done_id_d;
      end
   end

   // Ack marks the first CALC cycle, so it can never coincide with done.
   assign bus.ack0     = (state_q == StCalc) && (cnt_q == '0) && !id_q;
   assign bus.ack1     = (state_q == StCalc) && (cnt_q == '0) && id_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.done_id  = done_id_q;
   assign bus.result   = result_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Randomized and directed bench for addsub_share_ctrl against a transaction-level
// model that predicts grants, latencies and arithmetic results.
module tb_addsub_share_ctrl;
   localparam int unsigned W   = 16;
   localparam int unsigned NIB = W / 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   addsub_share_ctrl_if #(.WIDTH(W)) bus ();

   addsub_share_ctrl #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: edge counter, last grant edge and the values outputs must show.
   int         n      = 0;
   int         g_edge = -100;
   logic       lg     = 1'b1;
   logic       mid    = 1'b0;
   logic [W-1:0] m_r, e_r;
   logic       m_c, m_o, e_c, e_o, e_id;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic model_reset();
      g_edge = -100;
      lg     = 1'b1;
      e_r    = '0;
      e_c    = 1'b0;
      e_o    = 1'b0;
      e_id   = 1'b0;
   endtask

   task automatic compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] r, output logic c, output logic o);
      longint u, s, sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      u  = sub ? longint'(a) + ((longint'(1) << W) - longint'(b)) : longint'(a) + longint'(b);
      s  = sub ? sa - sb : sa + sb;
      r  = u[W-1:0];
      c  = (u >= (longint'(1) << W));
      o  = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
   endtask

   // One clock: advance model at the edge, compare every output at the falling edge.
   task automatic step();
      @(posedge clk);
      n++;
      if (n > g_edge + int'(NIB) + 1 && (bus.req0 || bus.req1)) begin
         mid    = (bus.req0 && bus.req1) ? ~lg : bus.req1;
         lg     = mid;
         g_edge = n;
         if (mid) compute(bus.a1, bus.b1, bus.sub1, m_r, m_c, m_o);
         else     compute(bus.a0, bus.b0, bus.sub0, m_r, m_c, m_o);
      end
      if (n == g_edge + int'(NIB)) begin
         e_r  = m_r;
         e_c  = m_c;
         e_o  = m_o;
         e_id = mid;
      end
      @(negedge clk);
      chk("ack0", 32'(bus.ack0), 32'(n == g_edge && !mid));
      chk("ack1", 32'(bus.ack1), 32'(n == g_edge && mid));
      chk("busy", 32'(bus.busy), 32'(n >= g_edge && n <= g_edge + int'(NIB)));
      chk("done", 32'(bus.done), 32'(n == g_edge + int'(NIB)));
      chk("done_id", 32'(bus.done_id), 32'(e_id));
      chk("result", 32'(bus.result), 32'(e_r));
      chk("carry", 32'(bus.carry), 32'(e_c));
      chk("overflow", 32'(bus.overflow), 32'(e_o));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, 32'({bus.ack0, bus.ack1}), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_done_id"}, 32'(bus.done_id), 32'd0);
      chk({tag, "_result"}, 32'(bus.result), 32'd0);
      chk({tag, "_carry_ovf"}, 32'({bus.carry, bus.overflow}), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Directed op with literal expectations; a is scrambled once operands are latched.
   task automatic run_op(input logic id, input logic sub, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] xr,
                         input logic xc, input logic xo);
      int bound = 0;
      int lat   = 0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (id) begin
         bus.req1 = 1'b1; bus.sub1 = sub; bus.a1 = a; bus.b1 = b;
      end else begin
         bus.req0 = 1'b1; bus.sub0 = sub; bus.a0 = a; bus.b0 = b;
      end
      do begin
         step();
         bound++;
      end while (g_edge != n && bound < 20);
      chk("grant_timeout", 32'(g_edge == n), 32'd1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (id) bus.a1 = 16'hAAAA;
      else    bus.a0 = 16'hAAAA;
      while (!bus.done && lat < 10) begin
         step();
         lat++;
      end
      // Done shows in the cycle after edge grant+NIB.
      chk("done_latency", 32'(lat), 32'd4);
      chk("lit_result", 32'(bus.result), 32'(xr));
      chk("lit_carry", 32'(bus.carry), 32'(xc));
      chk("lit_overflow", 32'(bus.overflow), 32'(xo));
      chk("lit_done_id", 32'(bus.done_id), 32'(id));
      chk("model_pin", 32'({e_r, e_c, e_o}), 32'({xr, xc, xo}));
      step();
      step();
   endtask

   initial begin
      int ids[4];
      int edges[4];
      int got;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.sub0 = 1'b0; bus.sub1 = 1'b0;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("init");
      rst = 1'b0;

      run_op(1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
      run_op(1'b1, 1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1);
      run_op(1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      run_op(1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);

      // Random traffic with arbitrary request levels and operand churn.
      for (int i = 0; i < 400; i++) begin
         bus.req0 = ($urandom_range(0, 2) != 0);
         bus.req1 = ($urandom_range(0, 2) != 0);
         bus.sub0 = 1'($urandom);
         bus.sub1 = 1'($urandom);
         bus.a0 = 16'($urandom); bus.b0 = 16'($urandom);
         bus.a1 = 16'($urandom); bus.b1 = 16'($urandom);
         step();
      end

      // Both requests held from reset: alternating grants, six cycles apart.
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      do_reset();
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.sub0 = 1'b0; bus.sub1 = 1'b1;
      bus.a0 = 16'h4321; bus.b0 = 16'h8765; bus.a1 = 16'h0100; bus.b1 = 16'h0200;
      got = 0;
      for (int i = 0; i < 40 && got < 4; i++) begin
         step();
         if (bus.ack0 || bus.ack1) begin
            ids[got]   = bus.ack1 ? 1 : 0;
            edges[got] = n;
            got++;
         end
      end
      chk("rr_grants_seen", 32'(got), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got) chk("rr_order", 32'(ids[i]), 32'(i % 2));
         if (i > 0 && i < got) chk("rr_spacing", 32'(edges[i] - edges[i-1]), 32'd6);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (8) step();

      // Reset while the third nibble is pending: no done may follow.
      bus.req0 = 1'b1; bus.sub0 = 1'b0; bus.a0 = 16'h1111; bus.b0 = 16'h2222;
      for (int i = 0; i < 20 && g_edge != n; i++) step();
      bus.req0 = 1'b0;
      step();
      step();
      chk("mid_busy_before", 32'(bus.busy), 32'd1);
      do_reset();
      repeat (8) step();
      run_op(1'b1, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
